sram_sp_masked_init: RTL

Parametrised single-port, byte-segment-masked SRAM model for the generated memory macros: one address port shared by reads and writes, per-segment write mask. Extends the fixed-geometry array models with:
- configurable depth, width, segment count and read latency;
- a hardware initialisation sweep after reset with a ready handshake;
- a read-valid strobe and held read data;
- defined out-of-range behaviour.

Sits under cache/TLB/predictor arrays wherever a deterministic post-reset memory image is needed.

---
 rtl/sram_model_pkg.sv | 25 ++
 rtl/sram_init_seq.sv | 56 +++++
 rtl/sram_sp_masked_init.sv | 119 +++++++++++
 3 files changed

// File: rtl/sram_model_pkg.sv
// Shared definitions for the generated SRAM models: init FSM state type,
// address-width helpers and the legal read-latency check.
package sram_model_pkg;

    typedef enum logic {S_INIT, S_READY} init_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << r) < 64'(value)) r = r + 1;
        end
        return r;
    endfunction

    // A one-entry-addressable array still needs a 1-bit address port.
    function automatic int addr_width(input int depth);
        return (clog2(depth) < 1) ? 1 : clog2(depth);
    endfunction

    function automatic bit latency_ok(input int latency);
        return (latency == 1) || (latency == 2);
    endfunction

endpackage

// File: rtl/sram_init_seq.sv
// Post-reset initialisation sequencer: walks every entry once, then raises
// a registered ready that stays high until the next reset.
module sram_init_seq
    import sram_model_pkg::*;
#(
    parameter int DEPTH         = 512,
    parameter int AW            = 9,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          init_we,
    output logic [AW-1:0] init_addr,
    output logic          ready
);

    localparam init_state_t   RESET_STATE = INIT_ON_RESET ? S_INIT : S_READY;
    localparam logic [AW-1:0] LAST_ADDR   = AW'(DEPTH - 1);

    init_state_t   state_reg, state_next;
    logic [AW-1:0] cnt_reg, cnt_next;
    logic          ready_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RESET_STATE;
            cnt_reg   <= '0;
            ready_reg <= !INIT_ON_RESET;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ready_reg <= (state_next == S_READY);
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        init_we    = 1'b0;
        case (state_reg)
            S_INIT: begin
                init_we  = 1'b1;
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == LAST_ADDR) begin
                    state_next = S_READY;
                    cnt_next   = '0;
                end
            end
            default: ;
        endcase
    end

    assign init_addr = cnt_reg;
    assign ready     = ready_reg;

endmodule

// File: rtl/sram_sp_masked_init.sv
// Single-port segment-masked SRAM model with post-reset init sweep,
// 1- or 2-cycle read pipeline, held read data and zero reads out of range.
module sram_sp_masked_init
    import sram_model_pkg::*;
#(
    parameter int               DEPTH         = 512,
    parameter int               WIDTH         = 210,
    parameter int               MASK_SEG      = 10,
    parameter int               LATENCY       = 1,
    parameter bit               INIT_ON_RESET = 1'b1,
    parameter logic [WIDTH-1:0] INIT_VALUE    = '0,
    localparam int              AW            = addr_width(DEPTH)
) (
    input  logic                RW0_clk,
    input  logic                RW0_rst_n,
    input  logic [AW-1:0]       RW0_addr,
    input  logic                RW0_en,
    input  logic                RW0_wmode,
    input  logic [MASK_SEG-1:0] RW0_wmask,
    input  logic [WIDTH-1:0]    RW0_wdata,
    output logic [WIDTH-1:0]    RW0_rdata,
    output logic                RW0_rvalid,
    output logic                RW0_ready
);

    localparam int            GRAN    = WIDTH / MASK_SEG;
    localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);

    generate
        if (!latency_ok(LATENCY)) begin : g_bad_latency
            $error("sram_sp_masked_init: LATENCY must be 1 or 2");
        end
        if (WIDTH % MASK_SEG != 0) begin : g_bad_mask
            $error("sram_sp_masked_init: WIDTH must be a multiple of MASK_SEG");
        end
    endgenerate

    logic [WIDTH-1:0] mem [DEPTH];

    logic          init_we;
    logic [AW-1:0] init_addr;
    logic          ready;

    sram_init_seq #(
        .DEPTH         (DEPTH),
        .AW            (AW),
        .INIT_ON_RESET (INIT_ON_RESET)
    ) u_init_seq (
        .clk       (RW0_clk),
        .rst_n     (RW0_rst_n),
        .init_we   (init_we),
        .init_addr (init_addr),
        .ready     (ready)
    );

    logic                in_range;
    logic                rd_fire;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [MASK_SEG-1:0] wr_mask;
    logic [WIDTH-1:0]    wr_data;

    assign in_range = ({1'b0, RW0_addr} < DEPTH_W);
    assign rd_fire  = RW0_en & ~RW0_wmode & ready;

    // The sweep owns the write port while it runs; the user port is gated off by ready.
    assign wr_en   = init_we | (RW0_en & RW0_wmode & ready & in_range);
    assign wr_addr = init_we ? init_addr : RW0_addr;
    assign wr_mask = init_we ? {MASK_SEG{1'b1}} : RW0_wmask;
    assign wr_data = init_we ? INIT_VALUE : RW0_wdata;

    always_ff @(posedge RW0_clk) begin
        if (wr_en) begin
            for (int s = 0; s < MASK_SEG; s++) begin
                if (wr_mask[s]) mem[wr_addr][s*GRAN +: GRAN] <= wr_data[s*GRAN +: GRAN];
            end
        end
    end

    logic             s1_valid_reg;
    logic [WIDTH-1:0] s1_data_reg;

    // Data only moves on a read, so the output holds between reads.
    always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
        if (!RW0_rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_data_reg  <= '0;
        end else begin
            s1_valid_reg <= rd_fire;
            if (rd_fire) s1_data_reg <= in_range ? mem[RW0_addr] : '0;
        end
    end

    generate
        if (LATENCY == 2) begin : g_lat2
            logic             s2_valid_reg;
            logic [WIDTH-1:0] s2_data_reg;

            always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
                if (!RW0_rst_n) begin
                    s2_valid_reg <= 1'b0;
                    s2_data_reg  <= '0;
                end else begin
                    s2_valid_reg <= s1_valid_reg;
                    if (s1_valid_reg) s2_data_reg <= s1_data_reg;
                end
            end

            assign RW0_rvalid = s2_valid_reg;
            assign RW0_rdata  = s2_data_reg;
        end else begin : g_lat1
            assign RW0_rvalid = s1_valid_reg;
            assign RW0_rdata  = s1_data_reg;
        end
    endgenerate

    assign RW0_ready = ready;

endmodule
